// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the divide unit
package div_unit_pkg;

    localparam int XLEN = 64;
    localparam int CNTW = 7;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_e;

    typedef struct packed {
        logic [15:0]           opid;
        logic [31:0]           ir;
        logic [1:0][XLEN-1:0]  prs;
        logic [6:0]            prda;
    } reg_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic [6:0]       prd;
        logic [XLEN-1:0]  res;
        logic             exc;
    } exe_bundle_t;

    // Widen a 32-bit operand for the W forms.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        return sgn ? {{32{v[31]}}, v} : {32'b0, v};
    endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - one combinational radix-2 restoring division step
//  i_rem      partial remainder (always < divisor)
//  i_dvd_msb  next dividend bit shifted out of the dividend register
//  i_dvs      divisor magnitude
//  o_rem      next partial remainder
//  o_qbit     next quotient bit
module div_core
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_dvd_msb,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // The shifted remainder needs one extra bit; since i_rem < i_dvs the
    // difference always fits in XLEN bits when non-negative, so bit XLEN
    // is a clean borrow flag.
    assign w_shift = {i_rem, i_dvd_msb};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV64M DIV/DIVU/REM/REMU (+W) unit with one response slot
//  clk    clock, rising edge
//  rst    asynchronous active-low reset
//  req    operand bundle, valid when req.opid[15]
//  ready  unit can accept req this cycle
//  flush  kill in-flight op and held response
//  resp   result bundle, valid when resp.opid[15]
//  claim  arbiter has taken resp
//  Optional macro DIV_FASTPATH_EN: trivial ops (divisor zero, MIN/-1,
//  |dividend| < |divisor|) bypass the iterative BUSY phase.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  reg_bundle_t req,
    output logic        ready,
    input  logic        flush,
    output exe_bundle_t resp,
    input  logic        claim
);

    div_state_e      r_state;
    div_state_e      w_next;
    logic [15:0]     r_opid;
    logic [6:0]      r_prd;
    logic            r_is_rem;
    logic            r_w;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_res;
    logic [CNTW-1:0] r_cnt;

    logic            w_w;
    logic            w_sgn;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_b_zero;
    logic            w_accept;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_q;
    logic [XLEN-1:0] w_fast_r;
    logic [XLEN-1:0] w_core_rem;
    logic            w_qbit;
    logic [XLEN-1:0] w_q;
    logic [XLEN-1:0] w_r;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_fix_res;
    logic            w_unused_ir;

    // funct3[0]=1 selects the unsigned forms, funct3[1]=1 the remainder.
    assign w_w         = req.ir[3];
    assign w_sgn       = ~req.ir[12];
    assign w_unused_ir = ^{req.ir[31:14], req.ir[11:4], req.ir[2:0]};

    assign w_a      = w_w ? ext32(req.prs[0][31:0], w_sgn) : req.prs[0];
    assign w_b      = w_w ? ext32(req.prs[1][31:0], w_sgn) : req.prs[1];
    assign w_a_neg  = w_sgn & w_a[XLEN-1];
    assign w_b_neg  = w_sgn & w_b[XLEN-1];
    assign w_a_abs  = w_a_neg ? -w_a : w_a;
    assign w_b_abs  = w_b_neg ? -w_b : w_b;
    assign w_b_zero = (w_b == '0);
    assign w_accept = req.opid[15] & (r_state == IDLE) & ~flush;

`ifdef DIV_FASTPATH_EN
    logic            w_ovf;
    logic [XLEN-1:0] w_min;

    assign w_min  = w_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_ovf  = w_sgn & (w_a == w_min) & (w_b == '1);
    assign w_fast = w_b_zero | w_ovf | (w_a_abs < w_b_abs);

    // Preload the magnitudes the iterative path would have produced so the
    // shared FIX stage yields bit-identical results.
    always_comb begin
        w_fast_q = '0;
        w_fast_r = w_a_abs;
        if (w_b_zero) begin
            w_fast_q = '1;
        end else if (w_ovf) begin
            w_fast_q = w_a_abs;
            w_fast_r = '0;
        end
    end
`else
    assign w_fast   = 1'b0;
    assign w_fast_q = '0;
    assign w_fast_r = '0;
`endif

    div_core u_core (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[XLEN-1]),
        .i_dvs     (r_dvs),
        .o_rem     (w_core_rem),
        .o_qbit    (w_qbit)
    );

    // For W ops the quotient ends up in r_dvd[31:0]; the 32 zero bits loaded
    // below the dividend have been shifted to the top by then.
    assign w_q       = r_neg_q ? -r_dvd : r_dvd;
    assign w_r       = r_neg_r ? -r_rem : r_rem;
    assign w_sel     = r_is_rem ? w_r : w_q;
    assign w_fix_res = r_w ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_fast ? FIX : BUSY;
            BUSY:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (claim) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_comb begin
        ready = (r_state == IDLE);
        resp  = '0;
        if (r_state == DONE) begin
            resp.opid = r_opid;
            resp.prd  = r_prd;
            resp.res  = r_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opid   <= '0;
            r_prd    <= '0;
            r_is_rem <= 1'b0;
            r_w      <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_opid   <= req.opid;
            r_prd    <= req.prda;
            r_is_rem <= req.ir[13];
            r_w      <= w_w;
            // Divide-by-zero keeps the all-ones quotient unnegated.
            r_neg_q  <= w_sgn & (w_a[XLEN-1] ^ w_b[XLEN-1]) & ~w_b_zero;
            r_neg_r  <= w_a_neg;
            r_dvs    <= w_b_abs;
            if (w_fast) begin
                r_dvd <= w_fast_q;
                r_rem <= w_fast_r;
                r_cnt <= '0;
            end else begin
                r_dvd <= w_w ? {w_a_abs[31:0], 32'b0} : w_a_abs;
                r_rem <= '0;
                r_cnt <= w_w ? CNTW'(XLEN/2 - 1) : CNTW'(XLEN - 1);
            end
        end else if (!flush && r_state == BUSY) begin
            r_rem <= w_core_rem;
            r_dvd <= {r_dvd[XLEN-2:0], w_qbit};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else if (!flush && r_state == FIX) begin
            r_res <= w_fix_res;
        end
    end

    a_claim_only_done: assert property (@(posedge clk) disable iff (!rst) claim |-> (r_state == DONE));

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        claim = 1'b0;
    reg_bundle_t req;
    logic        ready;
    exe_bundle_t resp;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .flush (flush),
        .resp  (resp),
        .claim (claim)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V division semantics using plain SV arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic               sgn;
        logic               rem;
        logic        [31:0] ua32, ub32, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic        [63:0] r64;
        sgn = !f3[0];
        rem = f3[1];
        if (w) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            sa32 = ua32;
            sb32 = ub32;
            if (ub32 == 0)
                r32 = rem ? ua32 : 32'hFFFF_FFFF;
            else if (sgn && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF)
                r32 = rem ? 32'h0 : 32'h8000_0000;
            else if (sgn)
                r32 = rem ? sa32 % sb32 : sa32 / sb32;
            else
                r32 = rem ? ua32 % ub32 : ua32 / ub32;
            return {{32{r32[31]}}, r32};
        end
        sa = a;
        sb = b;
        if (b == 0)
            r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r64 = rem ? 64'h0 : 64'h8000_0000_0000_0000;
        else if (sgn)
            r64 = rem ? sa % sb : sa / sb;
        else
            r64 = rem ? a % b : a / b;
        return r64;
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        bit          sgn;
        logic [63:0] ea, eb, ma, mb, mn;
        sgn = !f3[0];
        ea  = w ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
        eb  = w ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
        mn  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (eb == 0) return 1'b1;
        if (sgn && ea == mn && eb == 64'hFFFF_FFFF_FFFF_FFFF) return 1'b1;
        ma = (sgn && ea[63]) ? -ea : ea;
        mb = (sgn && eb[63]) ? -eb : eb;
        return ma < mb;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_FASTPATH_EN
        if (is_fast(f3, w, a, b)) return 2;
`endif
        return w ? 34 : 66;
    endfunction

    function automatic reg_bundle_t make_req(input logic [15:0] opid, input logic [2:0] f3,
                                             input logic w, input logic [63:0] a, input logic [63:0] b);
        reg_bundle_t r;
        r        = '0;
        r.opid   = opid;
        r.ir     = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, (w ? 7'b0111011 : 7'b0110011)};
        r.prs[0] = a;
        r.prs[1] = b;
        r.prda   = 7'(opid[6:0] + 7'd3);
        return r;
    endfunction

    // Issue one op, time its response and check contents; optionally claim it.
    task automatic run_op(input string tag, input logic [15:0] opid, input logic [2:0] f3,
                          input logic w, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input bit do_claim);
        int k;
        int spin;
        @(negedge clk);
        spin = 0;
        while (!ready && spin < 10) begin
            @(negedge clk);
            spin++;
        end
        chk({tag, " ready"}, 64'(ready), 64'd1);
        req = make_req(opid, f3, w, a, b);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) req = '0;
        end while (!resp.opid[15] && k < 200);
        chk({tag, " latency"}, 64'(k), 64'(exp_lat(f3, w, a, b)));
        chk({tag, " res"}, resp.res, exp_res);
        chk({tag, " opid"}, 64'(resp.opid), 64'(opid));
        chk({tag, " prd"}, 64'(resp.prd), 64'(7'(opid[6:0] + 7'd3)));
        if (do_claim) begin
            claim = 1'b1;
            @(negedge clk);
            claim = 1'b0;
            chk({tag, " idle after claim"}, 64'(ready), 64'd1);
            chk({tag, " resp cleared"}, 64'(resp.opid[15]), 64'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ha, hb, hres;
        logic [15:0] hop;
        logic [2:0]  f3;
        logic        w;
        int          sel;
        bit          seen;

        req = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset opid", 64'(resp.opid), 64'd0);
        chk("reset res", resp.res, 64'd0);
        chk("reset prd", 64'(resp.prd), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        vt[0]  = '{FUNCT3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14};
        vt[1]  = '{FUNCT3_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[2]  = '{FUNCT3_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        vt[3]  = '{FUNCT3_DIV,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vt[4]  = '{FUNCT3_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[5]  = '{FUNCT3_REMU, 1'b0, 64'd5, 64'd0, 64'd5};
        vt[6]  = '{FUNCT3_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vt[7]  = '{FUNCT3_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vt[8]  = '{FUNCT3_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[9]  = '{FUNCT3_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF};
        vt[10] = '{FUNCT3_DIV,  1'b1, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[11] = '{FUNCT3_REMU, 1'b1, 64'h1_0000_0003, 64'h5_0000_0000, 64'd3};
        vt[12] = '{FUNCT3_DIVU, 1'b0, 64'd3, 64'd100, 64'd0};
        vt[13] = '{FUNCT3_REM,  1'b0, 64'd7, -64'sd3, 64'd1};
        vt[14] = '{FUNCT3_DIV,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'h3FFF_FFFF_FFFF_FFFF};
        vt[15] = '{FUNCT3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), (i == 0) ? 16'h8005 : (16'h8010 | 16'(i)),
                   vt[i].f3, vt[i].w, vt[i].a, vt[i].b, vt[i].exp, 1'b1);
        end

        // Flush mid-BUSY, then a fresh op must be clean.
        @(negedge clk);
        req = make_req(16'h8100, FUNCT3_DIV, 1'b0, 64'd1000, 64'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy ready", 64'(ready), 64'd1);
        chk("flush busy no resp", 64'(resp.opid[15]), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (resp.opid[15]) seen = 1'b1;
        end
        chk("flush stale resp", 64'(seen), 64'd0);
        run_op("after flush", 16'h8101, FUNCT3_DIV, 1'b0, -64'sd1000, 64'd7,
               model(FUNCT3_DIV, 1'b0, -64'sd1000, 64'd7), 1'b1);

        // Flush in IDLE beats a valid request.
        @(negedge clk);
        req   = make_req(16'h8102, FUNCT3_DIVU, 1'b0, 64'd9, 64'd2);
        flush = 1'b1;
        @(negedge clk);
        req   = '0;
        flush = 1'b0;
        chk("idle flush no accept", 64'(ready), 64'd1);

        // Hold in DONE for 20 cycles, then flush+claim together.
        run_op("hold", 16'h8103, FUNCT3_REMU, 1'b0, 64'd1234567, 64'd1000, 64'd567, 1'b0);
        hres = resp.res;
        hop  = resp.opid;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (resp.res !== hres || resp.opid !== hop) seen = 1'b1;
        end
        chk("hold stable", 64'(seen), 64'd0);
        flush = 1'b1;
        claim = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        claim = 1'b0;
        chk("flush+claim cleared", 64'(resp.opid[15]), 64'd0);
        chk("flush+claim idle", 64'(ready), 64'd1);

        // Asynchronous reset mid-BUSY.
        @(negedge clk);
        req = make_req(16'h8104, FUNCT3_DIVU, 1'b0, 64'd12345, 64'd17);
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async reset ready", 64'(ready), 64'd1);
        chk("async reset resp", 64'(resp.opid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after reset", 16'h8105, FUNCT3_DIVU, 1'b0, 64'd12345, 64'd17, 64'd726, 1'b1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 400; i++) begin
            f3  = 3'b100 | 3'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            ha  = {$urandom(), $urandom()};
            hb  = {$urandom(), $urandom()};
            case (sel)
                0: hb = w ? {$urandom(), 32'h0} : 64'h0;
                1: begin
                    ha = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    hb = w ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: begin
                    ha = 64'($urandom_range(0, 200));
                    hb = 64'($urandom_range(1, 20));
                end
                3: ha = 64'($urandom_range(0, 50));
                4: hb = {32'h0, 16'h0, $urandom_range(1, 65535)};
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), 16'h8000 | 16'(i[14:0]), f3, w, ha, hb,
                   model(f3, w, ha, hb), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
